// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared constants, entry type and sizing helper for the IF/ID queue
package if_id_pkg;

  localparam int IF_ID_ADDR_W = 32;
  localparam int IF_ID_INST_W = 32;

  localparam logic [IF_ID_ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [IF_ID_INST_W-1:0] ZERO_INST = '0;

  typedef struct packed {
    logic [IF_ID_ADDR_W-1:0] pc;
    logic [IF_ID_INST_W-1:0] inst;
  } if_id_entry_t;

  // Pointer width never collapses to zero bits, even for a degenerate depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// rtl/if_id_queue_mem.sv - entry storage: one write port, one asynchronous read port
module if_id_queue_mem
  import if_id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ENT_W = 64
) (
  input  logic                       clk_in,
  input  logic                       we_in,
  input  logic [ptr_w(DEPTH)-1:0]    waddr_in,
  input  logic [ENT_W-1:0]           wdata_in,
  input  logic [ptr_w(DEPTH)-1:0]    raddr_in,
  output logic [ENT_W-1:0]           rdata_out
);

  logic [ENT_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we_in) begin
      r_mem[waddr_in] <= wdata_in;
    end
  end

  assign rdata_out = r_mem[raddr_in];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF->ID decoupling queue with bypass and registered ID-facing output
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic                         stall_in,
  input  logic                         inst_valid_in,
  input  logic [ADDR_W-1:0]            pc_in,
  input  logic [INST_W-1:0]            inst_in,
  output logic                         ready_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         valid_out,
  output logic [ADDR_W-1:0]            pc_out,
  output logic [INST_W-1:0]            inst_out
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + INST_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ZERO = ADDR_W'(ZERO_ADDR);
  localparam logic [INST_W-1:0] INST_ZERO = INST_W'(ZERO_INST);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;

  logic              w_ready;
  logic              w_push;
  logic              w_have;
  logic              w_pop;
  logic              w_bypass;
  logic              w_wr_en;
  logic [ENT_W-1:0]  w_head;

  assign w_ready  = (r_count != CNT_FULL);
  assign w_push   = inst_valid_in & w_ready & ~flush_in;
  assign w_have   = (r_count != '0);
  assign w_pop    = ~stall_in & w_have;
  // An empty, unstalled queue hands the fetch straight to the output register.
  assign w_bypass = ~stall_in & ~w_have & w_push;
  assign w_wr_en  = w_push & ~w_bypass & rst_in;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .ENT_W (ENT_W)
  ) u_mem (
    .clk_in    (clk_in),
    .we_in     (w_wr_en),
    .waddr_in  (r_wr_ptr),
    .wdata_in  ({pc_in, inst_in}),
    .raddr_in  (r_rd_ptr),
    .rdata_out (w_head)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_pc     <= PC_ZERO;
      r_inst   <= INST_ZERO;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_wr_en && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_wr_en && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end

      if (!stall_in) begin
        if (w_have) begin
          r_valid <= 1'b1;
          r_pc    <= w_head[ENT_W-1:INST_W];
          r_inst  <= w_head[INST_W-1:0];
        end else if (w_push) begin
          r_valid <= 1'b1;
          r_pc    <= pc_in;
          r_inst  <= inst_in;
        end else begin
          r_valid <= 1'b0;
          r_pc    <= PC_ZERO;
          r_inst  <= INST_ZERO;
        end
      end
    end
  end

  assign ready_out = w_ready;
  assign count_out = r_count;
  assign valid_out = r_valid;
  assign pc_out    = r_pc;
  assign inst_out  = r_inst;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;
  import if_id_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        stall_in;
  logic        inst_valid_in;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic        ready_out;
  logic [2:0]  count_out;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;

  int n_vec = 0;
  int n_err = 0;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .flush_in      (flush_in),
    .stall_in      (stall_in),
    .inst_valid_in (inst_valid_in),
    .pc_in         (pc_in),
    .inst_in       (inst_in),
    .ready_out     (ready_out),
    .count_out     (count_out),
    .valid_out     (valid_out),
    .pc_out        (pc_out),
    .inst_out      (inst_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [2:0] cnt);
    chk({tag, ".valid"}, 32'(valid_out), 32'(v));
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".count"}, 32'(count_out), 32'(cnt));
  endtask

  initial begin
    if_id_entry_t e;
    rst_in = 1'b0; flush_in = 1'b0; stall_in = 1'b0;
    inst_valid_in = 1'b1; pc_in = 32'h999; inst_in = 32'hdead;

    // reset held two cycles with a fetch presented
    cyc(); cyc();
    chk_out("reset", 1'b0, ZERO_ADDR, 3'd0);
    chk("reset.ready", 32'(ready_out), 32'd1);
    chk("reset.inst", inst_out, ZERO_INST);
    rst_in = 1'b1; inst_valid_in = 1'b0;
    cyc();
    chk_out("idle", 1'b0, 32'h0, 3'd0);

    // bypass
    e = '{pc: 32'h100, inst: 32'h13};
    inst_valid_in = 1'b1; pc_in = e.pc; inst_in = e.inst;
    cyc();
    chk_out("bypass", 1'b1, 32'h100, 3'd0);
    chk("bypass.inst", inst_out, 32'h13);

    // stall fill
    stall_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc_in = 32'h200 + 32'(4 * k); inst_in = 32'hA0 + 32'(k);
      cyc();
      chk_out("fill", 1'b1, 32'h100, 3'(k + 1));
    end
    chk("full.ready", 32'(ready_out), 32'd0);
    pc_in = 32'h210; inst_in = 32'hA4;
    cyc();
    chk_out("full.push", 1'b1, 32'h100, 3'd4);
    inst_valid_in = 1'b0; stall_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_out("drain", 1'b1, 32'h200 + 32'(4 * k), 3'(3 - k));
      chk("drain.inst", inst_out, 32'hA0 + 32'(k));
    end
    cyc();
    chk_out("bubble", 1'b0, 32'h0, 3'd0);

    // wrap-around at count 2
    stall_in = 1'b1; inst_valid_in = 1'b1;
    pc_in = 32'h500; cyc();
    pc_in = 32'h504; cyc();
    chk_out("wrap.pre", 1'b0, 32'h0, 3'd2);
    stall_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pc_in = 32'h508 + 32'(4 * k);
      cyc();
      chk_out("wrap", 1'b1, 32'h500 + 32'(4 * k), 3'd2);
    end
    inst_valid_in = 1'b0;
    cyc(); chk_out("wrap.d0", 1'b1, 32'h528, 3'd1);
    cyc(); chk_out("wrap.d1", 1'b1, 32'h52C, 3'd0);

    // flush with count 3 and a same-cycle push
    stall_in = 1'b1; inst_valid_in = 1'b1;
    pc_in = 32'h600; cyc();
    pc_in = 32'h604; cyc();
    pc_in = 32'h608; cyc();
    chk_out("flush.pre", 1'b1, 32'h52C, 3'd3);
    flush_in = 1'b1; pc_in = 32'h300;
    cyc();
    chk_out("flush", 1'b0, 32'h0, 3'd0);
    chk("flush.ready", 32'(ready_out), 32'd1);
    flush_in = 1'b0; inst_valid_in = 1'b0; stall_in = 1'b0;
    cyc();
    chk_out("flush.post", 1'b0, 32'h0, 3'd0);

    // flush during stall, then resume
    inst_valid_in = 1'b1; pc_in = 32'h6F0; cyc();
    stall_in = 1'b1; pc_in = 32'h700; cyc();
    chk_out("fstall.pre", 1'b1, 32'h6F0, 3'd1);
    flush_in = 1'b1; inst_valid_in = 1'b0;
    cyc();
    chk_out("fstall", 1'b0, 32'h0, 3'd0);
    flush_in = 1'b0; stall_in = 1'b0; inst_valid_in = 1'b1;
    pc_in = 32'h400; inst_in = 32'h33;
    cyc();
    chk_out("resume", 1'b1, 32'h400, 3'd0);
    chk("resume.inst", inst_out, 32'h33);
    inst_valid_in = 1'b0;
    cyc();
    chk_out("resume.bub", 1'b0, 32'h0, 3'd0);

    // reset mid-operation
    stall_in = 1'b1; inst_valid_in = 1'b1;
    pc_in = 32'h800; cyc();
    pc_in = 32'h804; cyc();
    rst_in = 1'b0;
    cyc();
    chk_out("midrst", 1'b0, 32'h0, 3'd0);
    rst_in = 1'b1; stall_in = 1'b0; inst_valid_in = 1'b0;
    cyc();
    chk_out("midrst.post", 1'b0, 32'h0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF→ID decoupling stage that replaces the single-entry IF/ID register with a DEPTH-entry instruction queue plus the ID-facing output register. IF can keep fetching while ID is stalled, up to DEPTH instructions. The block presents one {pc, inst} pair per cycle to ID, inserts zero bubbles when empty, and discards all queued and presented instructions on a jump/branch redirect. It sits between the fetch unit and the decoder and runs entirely on the rising edge of the core clock.

## Interface
Parameters:
- ADDR_W, 32, pc width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2

Ports:
- clk_in  in  1  core clock, all state on posedge
- rst_in  in  1  synchronous reset, active-low (0 = reset)
- flush_in  in  1  jump/branch redirect; kills queue and output register
- stall_in  in  1  ID hold request; 1 = output register holds
- inst_valid_in  in  1  IF presents a fetched instruction
- pc_in  in  ADDR_W  fetched pc
- inst_in  in  INST_W  fetched instruction
- ready_out  out  1  queue can accept a push this cycle
- count_out  out  $clog2(DEPTH+1)  entries currently queued, excluding the output register
- valid_out  out  1  pc_out/inst_out hold a real instruction
- pc_out  out  ADDR_W  pc to ID
- inst_out  out  INST_W  instruction to ID

## Operation
- Storage: DEPTH entries of {pc, inst}, with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and count from 0 to DEPTH.
- ready_out = (count != DEPTH). It is combinational from registered count only and has no path from stall_in.
- Push accepted: inst_valid_in & ready_out & !flush_in.
- Pop or load of the output register when stall_in = 0, in priority order:
  - count > 0: load the head entry, valid_out ← 1, increment rd_ptr.
  - Otherwise, if a push is accepted this cycle: bypass. Load pc_in/inst_in directly into the output register and do not write the queue.
  - Otherwise, load a bubble: pc_out = inst_out = 0, valid_out = 0.
- When stall_in = 1, the output register holds. Pushes still enter the queue.
- Simultaneous push and pop with count > 0: both occur and count is unchanged. This is legal at count = DEPTH only if the push was already qualified by ready_out (it is not), so a full queue accepts no push in that cycle.
- flush_in = 1 has priority over everything:
  - count, wr_ptr and rd_ptr ← 0; pc_out = inst_out = 0; valid_out ← 0.
  - The same-cycle inst_valid_in is dropped.
  - stall_in is ignored in this cycle.
- Reset (rst_in = 0 at posedge): same effect as flush. Reset values: count_out = 0, ready_out = 1, valid_out = 0, pc_out = 0, inst_out = 0. Storage contents are don't-care.
- Pushes while ready_out = 0 are ignored. IF must hold its request.

## Timing
- Empty queue, ID not stalled: the instruction appears on pc_out/inst_out one cycle after inst_valid_in (bypass). This matches the old single-register latency.
- Non-empty queue: each instruction reaches the output after all older entries, one per unstalled cycle.
- count_out and ready_out update on the posedge after the push or pop.
- Flush: queue and output are empty on the edge where flush_in is sampled. The first post-flush fetch can appear one cycle after it is pushed.
- Reset mid-operation: state is abandoned in one cycle with no drain.
- No combinational path from any input to any output, except ready_out from internal count.

## Structure
- Shared package if_id_pkg:
  - ZERO_ADDR / ZERO_INST constants
  - the entry struct typedef {pc, inst}
  - the pointer-width localparam helper
- Sub-module if_id_queue_mem: DEPTH×(ADDR_W+INST_W) register array with one write port and one asynchronous read port, write-enable gated by the push condition. Control (pointers, count, output register) stays in the top module.

## Test plan
- Reset: hold rst_in = 0 for 2 cycles with inst_valid_in = 1 → valid_out = 0, pc_out = 0, count_out = 0, ready_out = 1.
- Bypass: empty queue, stall_in = 0, push pc = 0x100, inst = 0x00000013 → next cycle valid_out = 1, pc_out = 0x100, count_out = 0.
- Stall fill: stall_in = 1, push 0x200/0x204/0x208/0x20C (DEPTH = 4) → count_out = 4, ready_out = 0, and a fifth push of 0x210 is ignored. Release the stall → outputs 0x200, 0x204, 0x208, 0x20C on consecutive cycles, then a bubble (valid_out = 0, pc_out = 0).
- Wrap-around: 10 cycles of push-and-pop with count held at 2 → pointers wrap and pc order is strictly increasing with no duplicates or losses.
- Flush: count_out = 3 and valid_out = 1, assert flush_in together with a push of 0x300 → next cycle count_out = 0, valid_out = 0, and 0x300 never appears.
- Flush during stall, then resume: stall_in = 1 and flush_in = 1 in the same cycle → output cleared. Next push 0x400 with stall_in = 0 → pc_out = 0x400 one cycle later.
